// File: rtl/lru_tracker_param.sv
`default_nettype none
// ============================================================================
// Module   : lru_tracker_param
// Purpose  : Tracks up to N_WAYS resident items out of N_ITEMS request lines
//            and keeps them in least-recently-used order. It drives one
//            occupancy light per item. When a new item arrives and every way
//            is full, the LRU item is evicted. Requests are sampled only on
//            clock edges where the tick enable is high.
//
// Ports    : clk          system clock, rising edge
//            rst          synchronous active-high reset (priority over tick)
//            tick         sample enable for b
//            b            request lines, bit i requests item i
//            l            occupancy lights, bit i set while item i resident
//            hit          1-cycle pulse, accepted request was already resident
//            evict_valid  1-cycle pulse, an item was evicted
//            evict_idx    index of last evicted item (holds between evictions)
//            occ          number of resident items
//            err          1-cycle pulse, request ignored (b not one-hot)
//            hit_cnt      saturating accepted-hit counter   (LRU_STATS_EN)
//            miss_cnt     saturating accepted-miss counter  (LRU_STATS_EN)
//
// Options  : define LRU_STATS_EN to add the hit_cnt / miss_cnt outputs.
//
// Revision : 1.0  initial parametrised release
// ============================================================================
module lru_tracker_param #(
  parameter int N_ITEMS = 5,
  parameter int N_WAYS  = 4,
  parameter int IDX_W   = $clog2(N_ITEMS),
  parameter int OCC_W   = $clog2(N_WAYS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [N_ITEMS-1:0] b,
  output logic [N_ITEMS-1:0] l,
  output logic               hit,
  output logic               evict_valid,
  output logic [IDX_W-1:0]   evict_idx,
  output logic [OCC_W-1:0]   occ,
  output logic               err
`ifdef LRU_STATS_EN
  ,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // --------------------------------------------------------------------------
  generate
    if (N_ITEMS < 2 || N_ITEMS > 32) begin : g_bad_items
      $error("lru_tracker_param: N_ITEMS=%0d outside 2..32", N_ITEMS);
    end
    if (N_WAYS < 1 || N_WAYS > N_ITEMS) begin : g_bad_ways
      $error("lru_tracker_param: N_WAYS=%0d outside 1..N_ITEMS", N_WAYS);
    end
  endgenerate

  localparam int                 c_last_way = N_WAYS - 1;
  localparam logic [N_ITEMS-1:0] c_one_item = {{(N_ITEMS-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State: age list (slot 0 = MRU, slot N_WAYS-1 = LRU), lights, outputs
  // --------------------------------------------------------------------------
  logic               r_valid [N_WAYS];
  logic [IDX_W-1:0]   r_idx   [N_WAYS];
  logic [N_ITEMS-1:0] r_l;
  logic [OCC_W-1:0]   r_occ;
  logic               r_hit;
  logic               r_evict_valid;
  logic [IDX_W-1:0]   r_evict_idx;
  logic               r_err;

  // --------------------------------------------------------------------------
  // Request classification
  // --------------------------------------------------------------------------
  logic               w_any;
  logic               w_multi;
  logic               w_accept;
  logic               w_reject;
  logic [IDX_W-1:0]   w_req_idx;

  assign w_any    = |b;
  // Clearing the lowest set bit leaves something only if two or more bits are set.
  assign w_multi  = |(b & (b - c_one_item));
  assign w_accept = tick & w_any & ~w_multi;
  assign w_reject = tick & w_multi;

  always_comb begin : p_encode
    w_req_idx = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (b[i]) begin
        w_req_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lookup: which slot (if any) holds the requested item
  // --------------------------------------------------------------------------
  logic [N_WAYS-1:0]  w_match;
  logic [N_WAYS-1:0]  w_at_or_below;
  logic               w_hit;
  logic               w_full;

  generate
    for (genvar j = 0; j < N_WAYS; j++) begin : g_match
      assign w_match[j] = r_valid[j] && (r_idx[j] == w_req_idx);
    end
  endgenerate

  // w_at_or_below[j] is set when the hit slot is j or older. On a hit,
  // exactly the slots 1..hit_slot take their younger neighbour's entry;
  // older slots keep their contents.
  always_comb begin : p_age_scan
    logic w_acc;
    w_acc         = 1'b0;
    w_at_or_below = '0;
    for (int j = N_WAYS - 1; j >= 0; j--) begin
      w_acc            = w_acc | w_match[j];
      w_at_or_below[j] = w_acc;
    end
  end

  assign w_hit  = w_at_or_below[0];
  // Valid slots are contiguous from slot 0, so the LRU slot being valid
  // means every way is occupied.
  assign w_full = r_valid[c_last_way];

  // --------------------------------------------------------------------------
  // Next light vector on a miss. A miss can never target the victim, so
  // clearing the victim and setting the new item cannot collide.
  // --------------------------------------------------------------------------
  logic [N_ITEMS-1:0] w_victim_oh;
  logic [N_ITEMS-1:0] w_l_next;

  assign w_victim_oh = c_one_item << r_idx[c_last_way];
  assign w_l_next    = w_full ? ((r_l & ~w_victim_oh) | b) : (r_l | b);

  // --------------------------------------------------------------------------
  // Sequential update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_WAYS; j++) begin
        r_valid[j] <= 1'b0;
        r_idx[j]   <= '0;
      end
      r_l           <= '0;
      r_occ         <= '0;
      r_hit         <= 1'b0;
      r_evict_valid <= 1'b0;
      r_evict_idx   <= '0;
      r_err         <= 1'b0;
    end else begin
      // Pulses default low; they are raised only by an accepted tick.
      r_hit         <= 1'b0;
      r_evict_valid <= 1'b0;
      r_err         <= w_reject;

      if (w_accept) begin
        // Requested item always becomes MRU.
        r_valid[0] <= 1'b1;
        r_idx[0]   <= w_req_idx;

        // A miss shifts the whole list (the old LRU falls off the end);
        // a hit shifts only the slots younger than the hit position.
        for (int j = 1; j < N_WAYS; j++) begin
          if (!w_hit || w_at_or_below[j]) begin
            r_valid[j] <= r_valid[j-1];
            r_idx[j]   <= r_idx[j-1];
          end
        end

        if (w_hit) begin
          r_hit <= 1'b1;
        end else begin
          r_l <= w_l_next;
          if (w_full) begin
            r_evict_valid <= 1'b1;
            r_evict_idx   <= r_idx[c_last_way];
          end else begin
            r_occ <= r_occ + OCC_W'(1);
          end
        end
      end
    end
  end

  assign l           = r_l;
  assign occ         = r_occ;
  assign hit         = r_hit;
  assign evict_valid = r_evict_valid;
  assign evict_idx   = r_evict_idx;
  assign err         = r_err;

  // --------------------------------------------------------------------------
  // Optional saturating hit / miss statistics
  // --------------------------------------------------------------------------
`ifdef LRU_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (r_hit_cnt != 16'hFFFF) begin
          r_hit_cnt <= r_hit_cnt + 16'd1;
        end
      end else begin
        if (r_miss_cnt != 16'hFFFF) begin
          r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_lru_tracker_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_lru_tracker_param
// Purpose  : Directed plus short random stimulus for lru_tracker_param
//            (N_ITEMS=5, N_WAYS=4, tick every 4th clock). A queue-based LRU
//            reference model pushes expected outputs when a tick is driven,
//            and they are popped and compared after the DUT edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_lru_tracker_param;

  localparam int N_ITEMS = 5;
  localparam int N_WAYS  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [4:0] b;
  logic [4:0] l;
  logic       hit;
  logic       evict_valid;
  logic [2:0] evict_idx;
  logic [2:0] occ;
  logic       err;
`ifdef LRU_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  lru_tracker_param #(
    .N_ITEMS (N_ITEMS),
    .N_WAYS  (N_WAYS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .b           (b),
    .l           (l),
    .hit         (hit),
    .evict_valid (evict_valid),
    .evict_idx   (evict_idx),
    .occ         (occ),
    .err         (err)
`ifdef LRU_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0] l;
    logic [2:0] occ;
    logic       hit;
    logic       ev;
    logic [2:0] eidx;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  int         m_list[$];   // front = MRU
  logic [2:0] m_eidx = 3'd0;
  int         m_hits = 0;
  int         m_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_l();
    logic [4:0] v;
    v = '0;
    foreach (m_list[i]) v[m_list[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_list.delete();
    m_eidx = 3'd0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_step(input logic [4:0] bv, output exp_t e);
    int k;
    int pos;
    e.hit = 1'b0;
    e.ev  = 1'b0;
    e.err = 1'b0;
    if (bv == 5'd0) begin
      k = 0;
    end else if ($countones(bv) > 1) begin
      e.err = 1'b1;
    end else begin
      k = 0;
      for (int i = 0; i < N_ITEMS; i++) if (bv[i]) k = i;
      pos = -1;
      foreach (m_list[i]) if (m_list[i] == k) pos = i;
      if (pos >= 0) begin
        e.hit = 1'b1;
        m_list.delete(pos);
        if (m_hits < 65535) m_hits++;
      end else begin
        if (m_miss < 65535) m_miss++;
        if (m_list.size() == N_WAYS) begin
          m_eidx = 3'(m_list.pop_back());
          e.ev   = 1'b1;
        end
      end
      m_list.push_front(k);
    end
    e.l    = model_l();
    e.occ  = 3'(m_list.size());
    e.eidx = m_eidx;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, ":sb_empty"}, 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, ":l"},           32'(l),           32'(e.l));
    chk({tag, ":occ"},         32'(occ),         32'(e.occ));
    chk({tag, ":hit"},         32'(hit),         32'(e.hit));
    chk({tag, ":evict_valid"}, 32'(evict_valid), 32'(e.ev));
    chk({tag, ":evict_idx"},   32'(evict_idx),   32'(e.eidx));
    chk({tag, ":err"},         32'(err),         32'(e.err));
    chk({tag, ":inv_pop"},     32'($countones(l)), 32'(occ));
    chk({tag, ":inv_max"},     32'(occ <= 3'(N_WAYS)), 32'd1);
  endtask

  // Three tick=0 edges with b already presented, then one tick edge.
  task automatic req(input logic [4:0] bv, input string tag);
    exp_t e;
    b    = bv;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, ":idle_hit"}, 32'(hit),         32'd0);
    chk({tag, ":idle_ev"},  32'(evict_valid), 32'd0);
    chk({tag, ":idle_err"}, 32'(err),         32'd0);
    chk({tag, ":idle_l"},   32'(l),           32'(model_l()));
    tick = 1'b1;
    model_step(bv, e);
    sbq.push_back(e);
    @(negedge clk);
    tick = 1'b0;
    compare_out(tag);
  endtask

  initial begin : stim
    logic [4:0] bv;
    int         r;

    // Reset with tick high and b unknown: reset must win.
    rst  = 1'b1;
    tick = 1'b1;
    b    = 5'bxxxxx;
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    b    = 5'b00000;
    model_reset();
    chk("rst:l",           32'(l),           32'd0);
    chk("rst:occ",         32'(occ),         32'd0);
    chk("rst:hit",         32'(hit),         32'd0);
    chk("rst:evict_valid", 32'(evict_valid), 32'd0);
    chk("rst:evict_idx",   32'(evict_idx),   32'd0);
    chk("rst:err",         32'(err),         32'd0);

    req(5'b00000, "idle0");

    // Fill phase with held requests (repeated hits, never evicting)
    repeat (3) req(5'b00001, "item0");
    chk("item0:l_dir", 32'(l), 32'h01);
    repeat (3) req(5'b00010, "item1");
    repeat (3) req(5'b00100, "item2");
    repeat (2) req(5'b01000, "item3");
    chk("fill:l_dir",   32'(l),           32'h0F);
    chk("fill:occ_dir", 32'(occ),         32'd4);
    chk("fill:ev_dir",  32'(evict_valid), 32'd0);

    req(5'b10000, "item4");
    chk("item4:ev_dir",   32'(evict_valid), 32'd1);
    chk("item4:eidx_dir", 32'(evict_idx),   32'd0);
    chk("item4:l_dir",    32'(l),           32'h1E);
`ifdef LRU_STATS_EN
    chk("stats:hit7",  32'(hit_cnt),  32'd7);
    chk("stats:miss5", 32'(miss_cnt), 32'd5);
`endif

    req(5'b00010, "hit1");
    chk("hit1:hit_dir", 32'(hit), 32'd1);
    chk("hit1:l_dir",   32'(l),   32'h1E);

    req(5'b00001, "refill0");
    chk("refill0:eidx_dir", 32'(evict_idx), 32'd2);
    chk("refill0:l_dir",    32'(l),         32'h1B);

    req(5'b00110, "multi");
    chk("multi:err_dir", 32'(err), 32'd1);
    chk("multi:l_dir",   32'(l),   32'h1B);

    // Request present but never ticked: nothing may change.
    b    = 5'b00100;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("notick:l",   32'(l),   32'h1B);
    chk("notick:occ", 32'(occ), 32'd4);
    chk("notick:hit", 32'(hit), 32'd0);
    chk("notick:err", 32'(err), 32'd0);

    // Short random mix of idle, multi-hot and one-hot requests.
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      bv = 5'b00000;
      else if (r == 1) bv = 5'b11000;
      else             bv = 5'(1 << $urandom_range(0, 4));
      req(bv, "rand");
    end

    // Reset mid-operation discards all state.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst2:l",         32'(l),         32'd0);
    chk("rst2:occ",       32'(occ),       32'd0);
    chk("rst2:evict_idx", 32'(evict_idx), 32'd0);
    req(5'b00100, "post_rst");
    chk("post_rst:l_dir", 32'(l), 32'h04);

`ifdef LRU_STATS_EN
    // Held hit on the MRU item every clock until the counter saturates.
    b    = 5'(1 << m_list[0]);
    tick = 1'b1;
    repeat (65536) @(negedge clk);
    tick = 1'b0;
    chk("stats:sat_hit",  32'(hit_cnt),  32'hFFFF);
    chk("stats:sat_miss", 32'(miss_cnt), 32'(m_miss));
    chk("stats:sat_l",    32'(l),        32'(model_l()));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stats:rst_hit",  32'(hit_cnt),  32'd0);
    chk("stats:rst_miss", 32'(miss_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
